// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the parametrised byte-enable single-port RAM.
package sp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Reset-free storage with byte-masked write port and a registered read port.
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int RDW_MODE   = RDW_READ_FIRST,
  parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  zero,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;

  assign old_word = mem[addr];

  // Byte merge is done as read-modify-write so one write port serves all masks.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_WIDTH; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merged;
  end

  // Read register holds its value between reads; zero masks out-of-range reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (re) begin
      if (zero)
        rdata <= '0;
      else if (RDW_MODE == RDW_WRITE_FIRST && we)
        rdata <= merged;
      else
        rdata <= old_word;
    end
  end

endmodule

// File: rtl/sp_ram_be.sv
// Single-port RAM top: clear engine FSM, request decode, range check, output pipeline.
module sp_ram_be
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1024,
  localparam int ADDR_WIDTH  = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk_ip,
  input  logic                    rst_ip,
  input  logic                    cs_ip,
  input  logic                    we_ip,
  input  logic                    oe_ip,
  input  logic [DATA_WIDTH/8-1:0] be_ip,
  input  logic [ADDR_WIDTH-1:0]   address_ip,
  input  logic [DATA_WIDTH-1:0]   data_ip,
  input  logic                    clear_ip,
  output logic [DATA_WIDTH-1:0]   data_op,
  output logic                    valid_op,
  output logic                    err_op,
  output logic                    busy_op
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  idle, oor, req_wr, req_rd;
  logic                  arr_we;
  logic [BE_WIDTH-1:0]   arr_be;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_vld1, rd_err1, wr_err1;

  assign idle   = (state == IDLE);
  assign oor    = ({1'b0, address_ip} >= DEPTH_L);
  assign req_wr = idle & cs_ip & we_ip;
  assign req_rd = idle & cs_ip & oe_ip;

  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == LAST) state_nxt = IDLE;
      IDLE:    if (clear_ip)    state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // The clear engine steals the array write port for the whole sweep.
  always_comb begin
    busy_op   = !idle;
    arr_we    = req_wr & ~oor;
    arr_be    = be_ip;
    arr_addr  = address_ip;
    arr_wdata = data_ip;
    if (!idle) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = cnt;
      arr_wdata = CLEAR_VALUE;
    end
  end

  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip)
      cnt <= '0;
    else if (!idle)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  sp_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RDW_MODE   (RDW_MODE),
    .BE_WIDTH   (BE_WIDTH)
  ) u_array (
    .clk   (clk_ip),
    .rst   (rst_ip),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .re    (req_rd),
    .zero  (oor),
    .rdata (rdata)
  );

  // Write-only range errors report next cycle; read errors travel with valid.
  always_ff @(posedge clk_ip or posedge rst_ip) begin
    if (rst_ip) begin
      rd_vld1 <= 1'b0;
      rd_err1 <= 1'b0;
      wr_err1 <= 1'b0;
    end else begin
      rd_vld1 <= req_rd;
      rd_err1 <= req_rd & oor;
      wr_err1 <= req_wr & ~oe_ip & oor;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  vld2, err2;
    logic [DATA_WIDTH-1:0] data2;

    always_ff @(posedge clk_ip or posedge rst_ip) begin
      if (rst_ip) begin
        vld2  <= 1'b0;
        err2  <= 1'b0;
        data2 <= '0;
      end else begin
        vld2 <= rd_vld1;
        err2 <= rd_err1;
        if (rd_vld1) data2 <= rdata;
      end
    end

    assign data_op  = data2;
    assign valid_op = vld2;
    assign err_op   = err2 | wr_err1;
  end else begin : g_lat1
    assign data_op  = rdata;
    assign valid_op = rd_vld1;
    assign err_op   = rd_err1 | wr_err1;
  end

endmodule

// File: tb/tb_sp_ram_be.sv
// Scoreboard bench: one READ_FIRST latency-1 RAM and one WRITE_FIRST latency-2 RAM share stimulus.
module tb_sp_ram_be;

  logic        clk = 1'b0;
  logic        rst, cs, we, oe, clear;
  logic [1:0]  be;
  logic [9:0]  addr;
  logic [15:0] din;
  logic [15:0] dout0, dout1;
  logic        vld0, vld1, err0, err1, busy0, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    bit          rd;
    logic [15:0] d;
    bit          e;
    int          c;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mdl [1000];
  bit          mbusy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_ram_be #(.DATA_WIDTH(16), .RAM_DEPTH(1000), .READ_LATENCY(1), .RDW_MODE(0),
              .CLEAR_VALUE(16'h0000)) dut0 (
    .clk_ip(clk), .rst_ip(rst), .cs_ip(cs), .we_ip(we), .oe_ip(oe), .be_ip(be),
    .address_ip(addr), .data_ip(din), .clear_ip(clear),
    .data_op(dout0), .valid_op(vld0), .err_op(err0), .busy_op(busy0));

  sp_ram_be #(.DATA_WIDTH(16), .RAM_DEPTH(1000), .READ_LATENCY(2), .RDW_MODE(1),
              .CLEAR_VALUE(16'h0000)) dut1 (
    .clk_ip(clk), .rst_ip(rst), .cs_ip(cs), .we_ip(we), .oe_ip(oe), .be_ip(be),
    .address_ip(addr), .data_ip(din), .clear_ip(clear),
    .data_op(dout1), .valid_op(vld1), .err_op(err1), .busy_op(busy1));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (vld0 || err0)) begin
      if (q0.size() == 0) check("d0_unexpected", {30'd0, vld0, err0}, 32'd0);
      else begin
        e = q0.pop_front();
        check("d0_valid", vld0, e.rd);
        check("d0_err", err0, e.e);
        if (e.rd) check("d0_data", dout0, e.d);
        check("d0_cycle", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (vld1 || err1)) begin
      if (q1.size() == 0) check("d1_unexpected", {30'd0, vld1, err1}, 32'd0);
      else begin
        e = q1.pop_front();
        check("d1_valid", vld1, e.rd);
        check("d1_err", err1, e.e);
        if (e.rd) check("d1_data", dout1, e.d);
        check("d1_cycle", cyc, e.c);
      end
    end
  end

  // Drive one request cycle and push what each RAM must return.
  task automatic req(input bit c, input bit w, input bit o, input logic [1:0] b,
                     input int a, input logic [15:0] d, input bit clr = 1'b0);
    logic [15:0] old, mrg;
    bit          oor;
    @(posedge clk); #1;
    cs = c; we = w; oe = o; be = b; addr = a[9:0]; din = d; clear = clr;
    if (c && !mbusy) begin
      oor = (a >= 1000);
      old = oor ? 16'h0000 : mdl[a];
      mrg = old;
      if (b[0]) mrg[7:0]  = d[7:0];
      if (b[1]) mrg[15:8] = d[15:8];
      if (w && !oor) mdl[a] = mrg;
      if (o) begin
        q0.push_back(exp_t'{rd: 1'b1, d: oor ? 16'h0 : old, e: oor, c: cyc + 1});
        q1.push_back(exp_t'{rd: 1'b1, d: oor ? 16'h0 : (w ? mrg : old), e: oor, c: cyc + 2});
      end else if (w && oor) begin
        q0.push_back(exp_t'{rd: 1'b0, d: 16'h0, e: 1'b1, c: cyc + 1});
        q1.push_back(exp_t'{rd: 1'b0, d: 16'h0, e: 1'b1, c: cyc + 1});
      end
    end
    if (clr && !mbusy) begin
      foreach (mdl[i]) mdl[i] = 16'h0000;
      mbusy = 1'b1;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    cs = 0; we = 0; oe = 0; clear = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; cs = 0; we = 0; oe = 0; clear = 0; be = 0; addr = 0; din = 0;
    q0.delete();
    q1.delete();
    foreach (mdl[i]) mdl[i] = 16'h0000;
    mbusy = 1'b1;
    @(negedge clk);
    check("rst_d0_data", dout0, 0);  check("rst_d1_data", dout1, 0);
    check("rst_d0_valid", vld0, 0);  check("rst_d1_valid", vld1, 0);
    check("rst_d0_err", err0, 0);    check("rst_d1_err", err1, 0);
    check("rst_d0_busy", busy0, 1);  check("rst_d1_busy", busy1, 1);
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Counts busy cycles; drops any held request at the edge busy falls.
  task automatic wait_clear();
    int n0 = 0, n1 = 0, t = 0;
    @(negedge clk);
    while ((busy0 || busy1) && t < 3000) begin
      n0 += int'(busy0);
      n1 += int'(busy1);
      t++;
      @(negedge clk);
    end
    cs = 0; we = 0; oe = 0; clear = 0;
    check("d0_busy_cycles", n0, 1000);
    check("d1_busy_cycles", n1, 1000);
    mbusy = 1'b0;
  endtask

  initial begin
    rst = 1; cs = 0; we = 0; oe = 0; clear = 0; be = 0; addr = 0; din = 0;
    mbusy = 1'b1;
    do_reset();
    // Write held across the whole clear must be dropped.
    cs = 1; we = 1; be = 2'b11; addr = 10'd5; din = 16'hBEEF;
    wait_clear();
    req(1, 0, 1, 2'b11, 5, 16'h0);
    idle();

    // Byte enables, then read right after the write.
    req(1, 1, 0, 2'b11, 7, 16'h1234);
    req(1, 1, 0, 2'b01, 7, 16'hABCD);
    req(1, 0, 1, 2'b11, 7, 16'h0);
    req(1, 1, 0, 2'b10, 7, 16'h5600);
    req(1, 0, 1, 2'b11, 7, 16'h0);
    idle();

    // Read-during-write.
    req(1, 1, 0, 2'b11, 3, 16'h1111);
    req(1, 1, 1, 2'b11, 3, 16'h2222);
    req(1, 0, 1, 2'b11, 3, 16'h0);
    req(1, 1, 1, 2'b01, 3, 16'h33CC);
    req(1, 0, 1, 2'b11, 3, 16'h0);
    idle(); idle();

    // Back-to-back reads.
    for (int i = 0; i < 3; i++) req(1, 1, 0, 2'b11, i, 16'h00A0 + 16'(i));
    for (int i = 0; i < 3; i++) req(1, 0, 1, 2'b11, i, 16'h0);
    idle(); idle(); idle();

    // Range boundaries.
    req(1, 1, 0, 2'b11, 23, 16'h7777);
    req(1, 1, 0, 2'b11, 999, 16'h9999);
    req(1, 0, 1, 2'b11, 1000, 16'h0);
    idle();
    req(1, 1, 0, 2'b11, 1023, 16'hDEAD);
    idle(); idle();
    req(1, 0, 1, 2'b11, 23, 16'h0);
    req(1, 0, 1, 2'b11, 999, 16'h0);
    req(1, 1, 1, 2'b11, 1001, 16'hFFFF);
    req(1, 0, 0, 2'b11, 23, 16'h0);
    idle(); idle(); idle();

    // Reset aborts an in-flight read, then a requested clear wipes the array.
    req(1, 0, 1, 2'b11, 7, 16'h0);
    do_reset();
    wait_clear();
    req(1, 0, 1, 2'b11, 7, 16'h0);
    req(1, 1, 0, 2'b11, 9, 16'h5555);
    req(1, 0, 1, 2'b11, 9, 16'h0);
    idle(); idle(); idle();
    req(0, 0, 0, 2'b00, 0, 16'h0, 1'b1);
    idle();
    wait_clear();
    req(1, 0, 1, 2'b11, 9, 16'h0);
    idle(); idle(); idle();

    check("d0_pending", q0.size(), 0);
    check("d1_pending", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
